// File: rtl/uart_system_pkg.sv
// Shared types for the UART system slice.
// Launch FSM state encoding and default byte width.
package uart_system_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } tx_state_t;

  // Number of bytes a push adds to the queue.
  function automatic int unsigned push_bytes(
    input logic push1,
    input logic push2
  );
    if (push2)
      return 2;
    else if (push1)
      return 1;
    else
      return 0;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte queue with 1- or 2-byte push and 1-byte pop.
// Ports: push1/push2 (narrow/wide write), pop, rd_data (head), count.
module byte_fifo
  import uart_system_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push1,
  input  logic                    push2,
  input  logic [2*DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [CW-1:0]           count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_hi;
  logic [CW-1:0]         n_in;
  logic                  any_push;

  assign any_push  = push1 | push2;
  assign wr_ptr_hi = wr_ptr + PW'(1);
  assign n_in      = CW'(push_bytes(push1, push2));
  assign rd_data   = mem[rd_ptr];

  // Contents need no reset: only the bookkeeping decides what is valid.
  always_ff @(posedge clk) begin
    if (any_push)
      mem[wr_ptr] <= push_data[DATA_WIDTH-1:0];
    if (push2)
      mem[wr_ptr_hi] <= push_data[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (any_push)
        wr_ptr <= wr_ptr + PW'(n_in);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + n_in - CW'(pop);
    end
  end

endmodule

// File: rtl/transmitter_frame_buffer.sv
// Byte queue plus launch sequencer feeding the UART transmitter.
// Ports: input_* push side, transmitter_* launch side, status pulses.
module transmitter_frame_buffer
  import uart_system_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 64,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = $clog2(BUSY_TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  input  logic                    input_wide,
  input  logic [2*DATA_WIDTH-1:0] input_data,
  output logic                    input_ready,
  input  logic                    transmitter_busy_synchronized,
  output logic                    transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]   transmitter_parallel_data,
  output logic                    fifo_empty,
  output logic                    overflow,
  output logic                    timeout_error
);

  tx_state_t             state;
  logic [TW-1:0]         tmo_cnt;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head;
  logic                  accept;
  logic                  push1;
  logic                  push2;
  logic                  pop;
  logic                  busy;

  assign busy = transmitter_busy_synchronized;

  // Two free slots are always kept, so a wide push never splits.
  assign input_ready = count <= CW'(FIFO_DEPTH - 2);
  assign fifo_empty  = count == '0;

  assign accept = input_valid & input_ready;
  assign push1  = accept & ~input_wide;
  assign push2  = accept & input_wide;
  assign pop    = (state == WAIT_DONE) & ~busy;

  byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push1     (push1),
    .push2     (push2),
    .push_data (input_data),
    .pop       (pop),
    .rd_data   (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                           <= IDLE;
      tmo_cnt                         <= '0;
      transmitter_parallel_data_valid <= 1'b0;
      transmitter_parallel_data       <= '0;
      overflow                        <= 1'b0;
      timeout_error                   <= 1'b0;
    end else begin
      overflow      <= input_valid & ~input_ready;
      timeout_error <= 1'b0;
      unique case (state)
        IDLE: begin
          // Busy already high means a frame we did not start; hold off.
          if (!fifo_empty && !busy) begin
            transmitter_parallel_data       <= head;
            transmitter_parallel_data_valid <= 1'b1;
            tmo_cnt                         <= '0;
            state                           <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (busy) begin
            transmitter_parallel_data_valid <= 1'b0;
            state                           <= WAIT_DONE;
          end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            // Byte stays at the head and is relaunched from IDLE.
            transmitter_parallel_data_valid <= 1'b0;
            timeout_error                   <= 1'b1;
            state                           <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!busy)
            state <= IDLE;
        end
        default: begin
          transmitter_parallel_data_valid <= 1'b0;
          state                           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/transmitter_frame_buffer.md
# transmitter_frame_buffer

Byte FIFO and launch sequencer between the system controller and the UART transmitter data synchronizer, in the reference_clk domain. It accepts 8-bit register-file read data and 16-bit ALU results, splits wide results into two bytes (low byte first), and queues them. It then hands the bytes to the transmitter one at a time, pacing each launch with the synchronized transmitter busy flag so that no byte is lost across the clock-domain boundary.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width.
- FIFO_DEPTH, 8, byte entries; power of two, ≥ 4.
- BUSY_TIMEOUT, 64, reference_clk cycles to wait for busy to rise before a relaunch; ≥ 4.

Ports:
- clk  in  1  reference_clk.
- reset  in  1  asynchronous, active-low reset (already synchronized upstream).
- input_valid  in  1  push request.
- input_wide  in  1  1 = push input_data[15:0] as two bytes; 0 = push input_data[7:0] only.
- input_data  in  2*DATA_WIDTH  payload.
- input_ready  out  1  1 when count ≤ FIFO_DEPTH-2.
- transmitter_busy_synchronized  in  1  busy flag after the 2-stage synchronizer.
- transmitter_parallel_data_valid  out  1  launch request to the data synchronizer.
- transmitter_parallel_data  out  DATA_WIDTH  byte being launched.
- fifo_empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse when a push is dropped.
- timeout_error  out  1  one-cycle pulse on a launch timeout.

## Operation
- Storage:
  - FIFO_DEPTH × DATA_WIDTH array.
  - Read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Count of $clog2(FIFO_DEPTH)+1 bits.
- Push (input_valid & input_ready):
  - Narrow push writes 1 byte. Wide push writes low byte at wr_ptr and high byte at wr_ptr+1.
  - The pointer wraps modulo FIFO_DEPTH.
- input_valid & !input_ready: nothing is written; overflow pulses next cycle. This applies to both narrow and wide pushes.
- FSM states:
  - IDLE: if count ≠ 0 and !busy, go to LAUNCH. Register data = mem[rd_ptr], valid = 1, clear the timeout counter.
  - LAUNCH: hold valid and data.
    - On busy = 1: valid = 0, go to WAIT_DONE.
    - Else, when the counter reaches BUSY_TIMEOUT-1: valid = 0, timeout_error pulses, go to IDLE. The byte is not popped and is relaunched.
  - WAIT_DONE: hold data. On busy = 0: pop (rd_ptr+1, count-1), go to IDLE.
- Simultaneous push and pop in the same cycle: count ← count + n − 1, where n ∈ {1, 2}. Both take effect on that edge.
- Busy already high in IDLE (a frame not launched by this block): the FSM stays in IDLE.
- Reset mid-operation clears the FIFO contents' bookkeeping (pointers and count) and the FSM. Bytes in flight are discarded.

## Timing
- Reset values:
  - input_ready = 1, fifo_empty = 1.
  - transmitter_parallel_data_valid = 0, transmitter_parallel_data = 0.
  - overflow = 0, timeout_error = 0.
  - FSM = IDLE, pointers = 0, count = 0.
- All outputs are registered, except input_ready and fifo_empty, which are decoded combinationally from the count register.
- Push at edge t into an empty FIFO with busy = 0: count = 1 after t, valid rises at edge t+1. Latency is 1 cycle.
- Valid stays high until the first cycle busy is sampled high. It then falls on the following edge.
- A pop occurs on the edge after busy is sampled low in WAIT_DONE. The next launch can start one edge later, giving a minimum 2-cycle gap between launches.
- Full: count = FIFO_DEPTH-1 already deasserts input_ready, so a wide push never splits.

## Structure
- Shared package (uart_system_pkg): FSM state enum (IDLE, LAUNCH, WAIT_DONE) and the default DATA_WIDTH constant.
- One sub-module: byte_fifo. It holds the array, pointers and count, and has push1/push2/pop ports.
- The FSM and the timeout counter live in transmitter_frame_buffer.

## Test plan
- Narrow push of 0xA5, with a busy model that rises 3 cycles after valid and stays high for 20 cycles → valid high for 4 cycles, data 0xA5. fifo_empty = 1 after busy falls plus 1 cycle.
- Wide push of 0x1234 → bytes launched 0x34 then 0x12, each with its own valid/busy handshake.
- Fill with 7 narrow pushes (0x01..0x07) while busy is stuck high → input_ready = 0 at count 7. An 8th push of 0xFF pulses overflow. Bytes later drain as 0x01..0x07 in order, and the pointer wrap is exercised on refill.
- Busy never rises, BUSY_TIMEOUT = 8 → timeout_error pulses after 8 valid cycles. The same byte is relaunched and count is unchanged.
- Wide push in the same cycle as a WAIT_DONE pop with count = 3 → count = 4, and byte order is preserved.
- Reset asserted during LAUNCH → valid = 0 immediately, fifo_empty = 1. After reset release, a new push of 0x5A launches normally.
